// File: rtl/xor_share_arbiter_pkg.sv
// Shared constants for the XOR-share arbiter: FSM encodings and
// default sizing, imported by the RTL and the bench.
package xor_share_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after
// last_grant (wrapping) wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  int w_j;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_j        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_j = (int'(last_grant) + k) % N_REQ;
      if (!any && req[w_j]) begin
        any           = 1'b1;
        gnt_onehot[w_j] = 1'b1;
        gnt_idx       = ID_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/xor_gate.sv
// Single-bit XOR cell; the shared datapath is a bank of these.
module xor_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  assign o_y = i_a ^ i_b;

endmodule

// File: rtl/xor_share_arbiter.sv
// One registered XOR datapath shared by N_REQ requesters under
// a round-robin IDLE/EXEC/RESP sequencer.
module xor_share_arbiter
  import xor_share_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id
);

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [ID_W-1:0]  r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;

  logic [N_REQ-1:0] w_gnt_oh;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_any;
  logic             w_hs;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic [WIDTH-1:0] w_x;

  rr_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req       (req_valid),
    .last_grant(r_last),
    .gnt_onehot(w_gnt_oh),
    .gnt_idx   (w_gnt_idx),
    .any       (w_any)
  );

  assign w_hs      = (r_state == ST_IDLE) && w_any;
  assign req_ready = w_hs ? w_gnt_oh : '0;

  // One-hot grant lets the operand mux be a plain AND-OR.
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_oh[i]) begin
        w_a_sel = w_a_sel | req_a[i*WIDTH +: WIDTH];
        w_b_sel = w_b_sel | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_xor
    xor_gate u_xor (
      .i_a(r_a[g]),
      .i_b(r_b[g]),
      .o_y(w_x[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= ID_W'(N_REQ - 1);
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_id    <= w_gnt_idx;
            r_last  <= w_gnt_idx;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_x;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule
